fp_mult_norm_round: RTL and testbench

- Parametrised, pipelined successor to the combinational multiplier normaliser, for the FP multiply datapath.
- Takes the raw significand product, the pre-biased exponent sum and the sign. Normalises, rounds (RNE), detects overflow/underflow, and emits a packed IEEE-style result.
- Two register stages with a valid/ready handshake, so it can sit between the significand multiplier and the FP unit writeback.
- NaN/Inf/denormal operand classification stays upstream.

---
 rtl/fp_pkg.sv | 27 ++
 rtl/fp_round_rne.sv | 63 ++++++
 rtl/fp_mult_norm_round.sv | 136 +++++++++++++
 tb/tb_fp_mult_norm_round.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared FP datapath package: default field widths, bias, saturated exponent,
// packed result layout and exception-flag bundle.
package fp_pkg;

   localparam int unsigned EXP_WIDTH_DEF  = 8;
   localparam int unsigned MANT_WIDTH_DEF = 23;
   localparam int unsigned BIAS           = (1 << (EXP_WIDTH_DEF - 1)) - 1;
   localparam int unsigned EXP_MAX        = (1 << EXP_WIDTH_DEF) - 1;

   typedef struct packed {
      logic                      sign;
      logic [EXP_WIDTH_DEF-1:0]  exp;
      logic [MANT_WIDTH_DEF-1:0] frac;
   } fp_result_t;

   typedef struct packed {
      logic overflow;
      logic underflow;
      logic inexact;
   } fp_flags_t;

   // All-ones exponent code (Inf/NaN) for an arbitrary exponent width.
   function automatic int unsigned fp_exp_max(input int unsigned w);
      return (1 << w) - 1;
   endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Combinational round/pack stage shared by the FP multiplier and adder.
// Takes a normalised fraction with guard/sticky bits and a signed exponent,
// rounds, then saturates to infinity or flushes to zero.
// Macro FP_MULT_NORM_RNE_EN: defined = round-to-nearest-even,
// undefined = truncation (no increment, no carry-out path).
module fp_round_rne
   import fp_pkg::*;
#(
   parameter int unsigned EXP_WIDTH  = EXP_WIDTH_DEF,
   parameter int unsigned MANT_WIDTH = MANT_WIDTH_DEF
) (
   input  logic [MANT_WIDTH-1:0]        i_frac,
   input  logic                         i_g,
   input  logic                         i_s,
   input  logic signed [EXP_WIDTH+1:0]  i_exp,
   output logic [MANT_WIDTH-1:0]        o_frac,
   output logic [EXP_WIDTH-1:0]         o_exp,
   output fp_flags_t                    o_flags
);

   localparam logic signed [EXP_WIDTH+1:0] ExpMaxS = (EXP_WIDTH+2)'(fp_exp_max(EXP_WIDTH));

   logic [MANT_WIDTH-1:0]        w_frac_rnd;
   logic signed [EXP_WIDTH+1:0]  w_exp_fin;
   logic                         w_ovf;
   logic                         w_unf;
`ifdef FP_MULT_NORM_RNE_EN
   logic                         w_round_up;
   logic [MANT_WIDTH:0]          w_sum;
`endif

   // Rounding increment; a carry out of the fraction bumps the exponent.
   always_comb begin
`ifdef FP_MULT_NORM_RNE_EN
      w_round_up = i_g & (i_s | i_frac[0]);
      w_sum      = {1'b0, i_frac} + {{MANT_WIDTH{1'b0}}, w_round_up};
      w_frac_rnd = w_sum[MANT_WIDTH-1:0];
      w_exp_fin  = i_exp + {{(EXP_WIDTH+1){1'b0}}, w_sum[MANT_WIDTH]};
`else
      w_frac_rnd = i_frac;
      w_exp_fin  = i_exp;
`endif
   end

   // Range check on the final exponent, then pack with saturation/flush.
   always_comb begin
      w_ovf = (w_exp_fin >= ExpMaxS);
      w_unf = w_exp_fin[EXP_WIDTH+1] | (w_exp_fin == '0);
      o_frac = w_frac_rnd;
      o_exp  = w_exp_fin[EXP_WIDTH-1:0];
      if (w_ovf) begin
         o_frac = '0;
         o_exp  = '1;
      end else if (w_unf) begin
         o_frac = '0;
         o_exp  = '0;
      end
      o_flags.overflow  = w_ovf;
      o_flags.underflow = w_unf;
      o_flags.inexact   = i_g | i_s | w_ovf | w_unf;
   end

endmodule

// File: rtl/fp_mult_norm_round.sv
// Two-stage normalise/round back end for the FP multiplier.
// Stage 1 normalises the raw significand product; stage 2 rounds and packs.
// Valid/ready handshake with full throughput; both stages stall together.
// Macro FP_MULT_NORM_RNE_EN selects RNE rounding (truncation when undefined).
module fp_mult_norm_round
   import fp_pkg::*;
#(
   parameter int unsigned EXP_WIDTH  = EXP_WIDTH_DEF,
   parameter int unsigned MANT_WIDTH = MANT_WIDTH_DEF
) (
   input  logic                               in_Clk,
   input  logic                               in_Rst,
   input  logic                               in_Valid,
   output logic                               out_Ready,
   input  logic                               in_Sign,
   input  logic signed [EXP_WIDTH+1:0]        in_Exp,
   input  logic [2*MANT_WIDTH+1:0]            in_Mant,
   output logic                               out_Valid,
   input  logic                               in_Ready,
   output logic [EXP_WIDTH+MANT_WIDTH:0]      out_Result,
   output logic                               out_Overflow,
   output logic                               out_Underflow,
   output logic                               out_Inexact
);

   localparam int unsigned M = MANT_WIDTH;

   // Stage 1 registers
   logic                         r_s1_valid;
   logic                         r_s1_sign;
   logic                         r_s1_zero;
   logic [M-1:0]                 r_s1_frac;
   logic                         r_s1_g;
   logic                         r_s1_s;
   logic signed [EXP_WIDTH+1:0]  r_s1_exp;

   // Stage 2 registers
   logic                         r_s2_valid;
   logic [EXP_WIDTH+M:0]         r_s2_result;
   fp_flags_t                    r_s2_flags;

   logic                         w_s1_adv;
   logic                         w_in_ready;
   logic [M-1:0]                 w_frac;
   logic                         w_g;
   logic                         w_s;
   logic signed [EXP_WIDTH+1:0]  w_exp;
   logic                         w_zero;
   logic [M-1:0]                 w_rnd_frac;
   logic [EXP_WIDTH-1:0]         w_rnd_exp;
   fp_flags_t                    w_rnd_flags;

   assign w_s1_adv   = !r_s2_valid | in_Ready;
   assign w_in_ready = !r_s1_valid | w_s1_adv;
   assign out_Ready  = w_in_ready;

   // Normalise: product is in [1,4); shift right by one when it is >= 2.
   always_comb begin
      w_zero = (in_Mant == '0);
      if (in_Mant[2*M+1]) begin
         w_frac = in_Mant[2*M:M+1];
         w_g    = in_Mant[M];
         w_s    = |in_Mant[M-1:0];
         w_exp  = in_Exp + {{(EXP_WIDTH+1){1'b0}}, 1'b1};
      end else begin
         w_frac = in_Mant[2*M-1:M];
         w_g    = in_Mant[M-1];
         w_s    = |in_Mant[M-2:0];
         w_exp  = in_Exp;
      end
   end

   // Stage 1 register: loads whenever it is empty or draining into stage 2.
   always_ff @(posedge in_Clk) begin
      if (in_Rst) begin
         r_s1_valid <= 1'b0;
         r_s1_sign  <= 1'b0;
         r_s1_zero  <= 1'b0;
         r_s1_frac  <= '0;
         r_s1_g     <= 1'b0;
         r_s1_s     <= 1'b0;
         r_s1_exp   <= '0;
      end else if (w_in_ready) begin
         r_s1_valid <= in_Valid;
         if (in_Valid) begin
            r_s1_sign <= in_Sign;
            r_s1_zero <= w_zero;
            r_s1_frac <= w_frac;
            r_s1_g    <= w_g;
            r_s1_s    <= w_s;
            r_s1_exp  <= w_exp;
         end
      end
   end

   fp_round_rne #(
      .EXP_WIDTH  (EXP_WIDTH),
      .MANT_WIDTH (MANT_WIDTH)
   ) u_round (
      .i_frac  (r_s1_frac),
      .i_g     (r_s1_g),
      .i_s     (r_s1_s),
      .i_exp   (r_s1_exp),
      .o_frac  (w_rnd_frac),
      .o_exp   (w_rnd_exp),
      .o_flags (w_rnd_flags)
   );

   // Stage 2 register: bubbles load zeros so flags read 0 whenever invalid.
   always_ff @(posedge in_Clk) begin
      if (in_Rst) begin
         r_s2_valid  <= 1'b0;
         r_s2_result <= '0;
         r_s2_flags  <= '0;
      end else if (w_s1_adv) begin
         r_s2_valid <= r_s1_valid;
         if (!r_s1_valid) begin
            r_s2_result <= '0;
            r_s2_flags  <= '0;
         end else if (r_s1_zero) begin
            r_s2_result <= {r_s1_sign, {(EXP_WIDTH+M){1'b0}}};
            r_s2_flags  <= '0;
         end else begin
            r_s2_result <= {r_s1_sign, w_rnd_exp, w_rnd_frac};
            r_s2_flags  <= w_rnd_flags;
         end
      end
   end

   assign out_Valid     = r_s2_valid;
   assign out_Result    = r_s2_result;
   assign out_Overflow  = r_s2_flags.overflow;
   assign out_Underflow = r_s2_flags.underflow;
   assign out_Inexact   = r_s2_flags.inexact;

endmodule

// File: tb/tb_fp_mult_norm_round.sv
// Scoreboard bench for fp_mult_norm_round (single-precision widths).
// Expected results follow FP_MULT_NORM_RNE_EN (RNE when defined, else truncation).
module tb_fp_mult_norm_round;
   import fp_pkg::*;

   localparam int unsigned EW = EXP_WIDTH_DEF;
   localparam int unsigned MW = MANT_WIDTH_DEF;

   logic                  in_Clk = 1'b0;
   logic                  in_Rst;
   logic                  in_Valid;
   logic                  out_Ready;
   logic                  in_Sign;
   logic signed [EW+1:0]  in_Exp;
   logic [2*MW+1:0]       in_Mant;
   logic                  out_Valid;
   logic                  in_Ready;
   logic [EW+MW:0]        out_Result;
   logic                  out_Overflow;
   logic                  out_Underflow;
   logic                  out_Inexact;

   typedef struct {
      logic [31:0] res;
      fp_flags_t   flg;
      time         t_acc;
      bit          chk_lat;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_chk = 0;
   int   n_err = 0;
   int   occ   = 0;
   bit   prev_stall = 1'b0;
   logic [31:0] prev_res;
   logic [2:0]  prev_flg;

   fp_mult_norm_round #(
      .EXP_WIDTH  (EW),
      .MANT_WIDTH (MW)
   ) dut (
      .in_Clk        (in_Clk),
      .in_Rst        (in_Rst),
      .in_Valid      (in_Valid),
      .out_Ready     (out_Ready),
      .in_Sign       (in_Sign),
      .in_Exp        (in_Exp),
      .in_Mant       (in_Mant),
      .out_Valid     (out_Valid),
      .in_Ready      (in_Ready),
      .out_Result    (out_Result),
      .out_Overflow  (out_Overflow),
      .out_Underflow (out_Underflow),
      .out_Inexact   (out_Inexact)
   );

   always #5 in_Clk = ~in_Clk;

   function automatic logic [31:0] pack(input logic s, input logic [7:0] e, input logic [22:0] f);
      fp_result_t r;
      r.sign = s;
      r.exp  = e;
      r.frac = f;
      return r;
   endfunction

   function automatic fp_flags_t fl(input logic o, input logic u, input logic i);
      fp_flags_t f;
      f.overflow  = o;
      f.underflow = u;
      f.inexact   = i;
      return f;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Present one operand and hold it until accepted; record expectation on accept.
   task automatic send(input logic s, input logic signed [9:0] e, input logic [47:0] m,
                       input logic [31:0] res, input fp_flags_t f, input bit lat);
      int  w;
      bit  done;
      @(posedge in_Clk);
      #1;
      in_Valid = 1'b1;
      in_Sign  = s;
      in_Exp   = e;
      in_Mant  = m;
      w    = 0;
      done = 1'b0;
      while (!done) begin
         @(negedge in_Clk);
         if (out_Ready) begin
            sb.push_back('{res, f, $time, lat});
            done = 1'b1;
         end else if (++w > 50) begin
            n_err++;
            $display("FAIL accept_timeout: out_Ready stuck 0, expected 1 within 50 cycles");
            done = 1'b1;
         end
      end
   endtask

   task automatic idle_in();
      @(posedge in_Clk);
      #1;
      in_Valid = 1'b0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (sb.size() != 0 && w < 100) begin
         @(negedge in_Clk);
         w++;
      end
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
         sb.delete();
      end
      repeat (3) @(negedge in_Clk);
   endtask

   // Monitor: ready model, stall stability, idle flags, and scoreboard pops.
   always @(negedge in_Clk) begin
      if (in_Rst) begin
         occ        = 0;
         prev_stall = 1'b0;
      end else begin
         chk("out_ready", {31'b0, out_Ready}, {31'b0, (occ < 2) || in_Ready});
         if (prev_stall) begin
            chk("stall_valid", {31'b0, out_Valid}, 32'd1);
            chk("stall_result", out_Result, prev_res);
            chk("stall_flags", {29'b0, out_Overflow, out_Underflow, out_Inexact},
                {29'b0, prev_flg});
         end
         if (!out_Valid)
            chk("idle_flags", {29'b0, out_Overflow, out_Underflow, out_Inexact}, 32'd0);
         if (out_Valid && in_Ready) begin
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_output: got %h, expected no output", out_Result);
            end else begin
               exp_t e;
               e = sb.pop_front();
               n_vec++;
               chk("result", out_Result, e.res);
               chk("flags", {29'b0, out_Overflow, out_Underflow, out_Inexact}, {29'b0, e.flg});
               if (e.chk_lat)
                  chk("latency", 32'(($time - e.t_acc) / 10), 32'd2);
            end
         end
         occ = occ + ((in_Valid && out_Ready) ? 1 : 0) - ((out_Valid && in_Ready) ? 1 : 0);
         prev_stall = out_Valid && !in_Ready;
         prev_res   = out_Result;
         prev_flg   = {out_Overflow, out_Underflow, out_Inexact};
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit pat[20] = '{1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 1, 0, 1, 1};
      logic [31:0] r_tie_odd;
      logic [31:0] r_carry;

`ifdef FP_MULT_NORM_RNE_EN
      r_tie_odd = 32'h3F800002;
      r_carry   = 32'h40000000;
`else
      r_tie_odd = 32'h3F800001;
      r_carry   = 32'h3FFFFFFF;
`endif

      in_Rst   = 1'b1;
      in_Valid = 1'b0;
      in_Ready = 1'b1;
      in_Sign  = 1'b0;
      in_Exp   = '0;
      in_Mant  = '0;
      repeat (2) @(posedge in_Clk);
      #1;
      in_Rst = 1'b0;
      @(negedge in_Clk);
      chk("rst_valid", {31'b0, out_Valid}, 32'd0);
      chk("rst_result", out_Result, 32'd0);
      chk("rst_flags", {29'b0, out_Overflow, out_Underflow, out_Inexact}, 32'd0);
      chk("rst_ready", {31'b0, out_Ready}, 32'd1);

      // Directed vectors, downstream always ready.
      send(1'b0, 10'sd127, 48'h900000000000, 32'h40100000, fl(0, 0, 0), 1'b1);
      send(1'b0, 10'sd127, {2'b01, 23'h000001, 1'b1, 22'h0}, r_tie_odd, fl(0, 0, 1), 1'b0);
      send(1'b0, 10'sd127, {2'b01, 23'h000002, 1'b1, 22'h0}, 32'h3F800002, fl(0, 0, 1), 1'b0);
      send(1'b0, 10'sd127, {2'b01, 23'h7FFFFF, 1'b1, 22'h1}, r_carry, fl(0, 0, 1), 1'b0);
      send(1'b0, 10'sd254, 48'h800000000000, pack(1'b0, 8'(EXP_MAX), 23'h0), fl(1, 0, 1), 1'b0);
      send(1'b1, 10'sd0, 48'h400000000000, 32'h80000000, fl(0, 1, 1), 1'b0);
      send(1'b1, 10'sd127, 48'h000000000000, 32'h80000000, fl(0, 0, 0), 1'b0);
      send(1'b0, 10'sd254, 48'h400000000000, 32'h7F000000, fl(0, 0, 0), 1'b0);
      send(1'b0, 10'sd1, 48'h400000000000, 32'h00800000, fl(0, 0, 0), 1'b0);
      send(1'b0, -10'sd5, 48'h800000000000, 32'h00000000, fl(0, 1, 1), 1'b0);
      send(1'b1, 10'(BIAS), 48'h400000000000, pack(1'b1, 8'(BIAS), 23'h0), fl(0, 0, 0), 1'b0);
      idle_in();
      drain();

      // Back-to-back stream under toggling backpressure.
      fork
         begin
            for (int i = 0; i < 8; i++)
               send(1'b0, 10'(100 + i), 48'h400000000000, pack(1'b0, 8'(100 + i), 23'h0),
                    fl(0, 0, 0), 1'b0);
            idle_in();
         end
         begin
            for (int k = 0; k < 20; k++) begin
               @(posedge in_Clk);
               #1;
               in_Ready = pat[k];
            end
            @(posedge in_Clk);
            #1;
            in_Ready = 1'b1;
         end
      join
      drain();

      // Fill both stages, then reset mid-flight.
      @(posedge in_Clk);
      #1;
      in_Ready = 1'b0;
      send(1'b0, 10'sd130, 48'h400000000000, 32'h41000000, fl(0, 0, 0), 1'b0);
      send(1'b0, 10'sd131, 48'h400000000000, 32'h41800000, fl(0, 0, 0), 1'b0);
      @(posedge in_Clk);
      #1;
      in_Valid = 1'b0;
      in_Rst   = 1'b1;
      sb.delete();
      @(posedge in_Clk);
      #1;
      in_Rst = 1'b0;
      @(negedge in_Clk);
      chk("midrst_valid", {31'b0, out_Valid}, 32'd0);
      chk("midrst_flags", {29'b0, out_Overflow, out_Underflow, out_Inexact}, 32'd0);
      chk("midrst_ready", {31'b0, out_Ready}, 32'd1);
      @(posedge in_Clk);
      #1;
      in_Ready = 1'b1;
      send(1'b0, 10'sd127, 48'h400000000000, 32'h3F800000, fl(0, 0, 0), 1'b1);
      idle_in();
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
